// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM encoding and parity constants for the serial parity checker.
package parity_pkg;
  typedef enum logic [1:0] {COLLECT, PARITY, REPORT} state_t;
  localparam int DEF_DATA_BITS = 3;
  localparam bit PAR_ODD = 1'b1;
  localparam bit PAR_EVEN = 1'b0;
endpackage

// File: rtl/parity_checker_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/parity_checker.sv
// parity_checker: deserialises DATA_BITS data bits plus one parity bit per frame and flags parity errors.
// Define PARITY_CNT_EN to add the saturating err_count output.
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter bit ODD_PARITY = PAR_ODD,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  output logic                 parity_err
`ifdef PARITY_CNT_EN
  ,output logic [CNT_W-1:0]    err_count
`endif
);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  state_t r_state, w_next;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic [IDX_W-1:0] r_idx, w_idx_base;
  logic r_par, w_par_base, w_bit_in, w_par_in, w_restart, w_last;
  logic [DATA_BITS:0] w_cat;
  assign w_cat      = {in, r_shift};
  assign w_shift    = w_cat[DATA_BITS:1];
  assign w_restart  = r_state == REPORT;
  assign w_bit_in   = in_valid && r_state != PARITY;
  assign w_par_in   = in_valid && r_state == PARITY;
  assign w_idx_base = w_restart ? '0 : r_idx;
  assign w_par_base = w_restart ? 1'b0 : r_par;
  assign w_last     = w_idx_base == IDX_W'(DATA_BITS - 1);
  always_comb begin
    w_next = COLLECT;
    w_next = r_state == PARITY ? (in_valid ? REPORT : PARITY)
           : (w_bit_in && w_last) ? PARITY : COLLECT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= COLLECT;
    else r_state <= w_next;
  // REPORT always restarts the frame; a bit arriving in REPORT becomes bit 0 of the next one
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_shift    <= '0;
      r_idx      <= '0;
      r_par      <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      out_valid <= w_par_in;
      if (w_restart) begin
        r_idx <= '0;
        r_par <= 1'b0;
      end
      if (w_bit_in) begin
        r_shift <= w_shift;
        r_idx   <= w_idx_base + 1'b1;
        r_par   <= w_par_base ^ in;
      end
      if (w_par_in) begin
        data_out   <= r_shift;
        parity_err <= r_par ^ in ^ ODD_PARITY;
      end
    end
`ifdef PARITY_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (reset),
    .inc  (w_par_in && (r_par ^ in ^ ODD_PARITY)),
    .count(err_count)
  );
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif
endmodule

// File: tb/tb_parity_checker.sv
// tb_parity_checker: directed-vector bench for parity_checker (DATA_BITS=3, odd parity, CNT_W=2).
module tb_parity_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in = 1'b0;
  logic [2:0] data_out;
  logic out_valid;
  logic parity_err;
`ifdef PARITY_CNT_EN
  logic [1:0] err_count;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_cyc[$];
  logic [2:0] q_data[$];
  logic q_err[$];

  parity_checker #(.DATA_BITS(3), .ODD_PARITY(1'b1), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .parity_err(parity_err)
`ifdef PARITY_CNT_EN
    ,.err_count(err_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (out_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_data.push_back(data_out);
      q_err.push_back(parity_err);
    end

  task automatic clear_q();
    q_cyc.delete();
    q_data.delete();
    q_err.delete();
  endtask

  task automatic send(input logic b);
    @(negedge clk);
    in_valid = 1'b1;
    in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks += 3;
    if (data_out !== 3'b000) begin errors++; $display("FAIL reset_data: got %b want 000", data_out); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", parity_err); end
`ifdef PARITY_CNT_EN
    checks++;
    if (err_count !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", err_count); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int exp_cyc;
    clear_q();
    send(1); send(0); send(1); send(1);
    exp_cyc = cyc + 1;
    idle(3);
    #1;
    checks++;
    if (q_cyc.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks += 3;
      if (q_cyc[0] != exp_cyc) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", q_cyc[0], exp_cyc); end
      if (q_data[0] !== 3'b101) begin errors++; $display("FAIL basic_data: got %b want 101", q_data[0]); end
      if (q_err[0] !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", q_err[0]); end
    end
  endtask

  task automatic test_bad_parity();
    clear_q();
    send(1); send(1); send(0); send(0);
    idle(3);
    #1;
    checks++;
    if (q_cyc.size() != 1) begin errors++; $display("FAIL bad_pulses: got %0d want 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks += 2;
      if (q_data[0] !== 3'b011) begin errors++; $display("FAIL bad_data: got %b want 011", q_data[0]); end
      if (q_err[0] !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", q_err[0]); end
    end
`ifdef PARITY_CNT_EN
    checks++;
    if (err_count !== 2'd1) begin errors++; $display("FAIL bad_cnt: got %0d want 1", err_count); end
`endif
  endtask

  task automatic test_gaps();
    int exp_cyc;
    logic [3:0] bits;
    bits = 4'b1110;
    clear_q();
    for (int i = 0; i < 4; i++) begin
      send(bits[i]);
      if (i == 3) exp_cyc = cyc + 1;
      if (i < 3) idle(2);
    end
    idle(4);
    #1;
    checks += 3;
    if (q_cyc.size() != 1) begin errors++; $display("FAIL gaps_pulses: got %0d want 1", q_cyc.size()); end
    if (data_out !== 3'b110) begin errors++; $display("FAIL gaps_hold_data: got %b want 110", data_out); end
    if (parity_err !== 1'b0) begin errors++; $display("FAIL gaps_hold_err: got %b want 0", parity_err); end
    if (q_cyc.size() > 0) begin
      checks += 2;
      if (q_cyc[0] != exp_cyc) begin errors++; $display("FAIL gaps_latency: got cycle %0d want %0d", q_cyc[0], exp_cyc); end
      if (q_data[0] !== 3'b110) begin errors++; $display("FAIL gaps_data: got %b want 110", q_data[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b1010_0001;
    clear_q();
    for (int i = 0; i < 8; i++) send(bits[i]);
    idle(3);
    #1;
    checks++;
    if (q_cyc.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", q_cyc.size()); end
    if (q_cyc.size() == 2) begin
      checks += 5;
      if (q_cyc[1] - q_cyc[0] != 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", q_cyc[1] - q_cyc[0]); end
      if (q_data[0] !== 3'b001) begin errors++; $display("FAIL b2b_data0: got %b want 001", q_data[0]); end
      if (q_err[0] !== 1'b0) begin errors++; $display("FAIL b2b_err0: got %b want 0", q_err[0]); end
      if (q_data[1] !== 3'b010) begin errors++; $display("FAIL b2b_data1: got %b want 010", q_data[1]); end
      if (q_err[1] !== 1'b1) begin errors++; $display("FAIL b2b_err1: got %b want 1", q_err[1]); end
    end
`ifdef PARITY_CNT_EN
    checks++;
    if (err_count !== 2'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", err_count); end
`endif
  endtask

  task automatic test_abort();
    clear_q();
    send(1); send(1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 3'b000) begin errors++; $display("FAIL abort_async_data: got %b want 000", data_out); end
`ifdef PARITY_CNT_EN
    checks++;
    if (err_count !== 2'd0) begin errors++; $display("FAIL abort_async_cnt: got %0d want 0", err_count); end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    send(0); send(0); send(0); send(1);
    idle(3);
    #1;
    checks++;
    if (q_cyc.size() != 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", q_cyc.size()); end
    if (q_cyc.size() > 0) begin
      checks += 2;
      if (q_data[0] !== 3'b000) begin errors++; $display("FAIL abort_data: got %b want 000", q_data[0]); end
      if (q_err[0] !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", q_err[0]); end
    end
  endtask

  task automatic test_saturate();
`ifdef PARITY_CNT_EN
    logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int f = 0; f < 5; f++) begin
      send(1); send(1); send(0); send(0);
      idle(2);
      checks++;
      if (err_count !== exp_cnt[f]) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", f, err_count, exp_cnt[f]); end
    end
`else
    clear_q();
    for (int f = 0; f < 2; f++) begin
      send(1); send(1); send(0); send(0);
      idle(2);
    end
    #1;
    checks++;
    if (q_cyc.size() != 2) begin errors++; $display("FAIL repeat_pulses: got %0d want 2", q_cyc.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_parity();
    test_gaps();
    test_back_to_back();
    test_abort();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
